cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  async active-high reset.
REQ-004 instr_in  in  16  instruction word; captured into IR when load_ir=1.
REQ-005 load_ir  in  1  IR load enable.
REQ-006 reg_sel  in  2  register pointer: 00=Rm, 01=Rd, 10=Rn, 11=Rm.
REQ-007 wb_sel  in  2  writeback source: 00=C, 01={8'b0,pc}, 10=sximm8, 11=mdata.
REQ-008 w_en, en_A, en_B, en_C, en_status  in  1 each  write / register load enables.
REQ-009 sel_A  in  1  1: ALU A operand=16'h0000; 0: A register.
REQ-010 sel_B  in  1  1: B operand=sximm5; 0: shifter output.
REQ-011 mdata  in  16  memory read data.  pc  in  8  program counter.
REQ-012 opcode  out  3  IR[15:13].  ALU_op  out  2  IR[12:11].  shift_op  out  2  IR[4:3].
REQ-013 datapath_out  out  16  C register.  Z, N, V  out  1 each  status register.

Function
REQ-014 IR fields: Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0], imm8=IR[7:0], imm5=IR[4:0]; sximm8/sximm5 sign-extended to 16 bits.
REQ-015 Register file R0-R7, 16-bit; combinational read at the register selected by reg_sel.
REQ-016 Write on rising edge when w_en=1: R[reg_sel pointer] <= wb_sel source.
REQ-017 A <= read data when en_A=1; B <= read data when en_B=1; same edge as a write to the same register captures the OLD value (no bypass).
REQ-018 Shifter on B: 00 pass, 01 LSL by 1 (zero fill), 10 LSR by 1 (zero fill), 11 ASR by 1 (bit 15 kept).
REQ-019 ALU: 00 A+B, 01 A-B, 10 A&B, 11 ~B; result truncated to 16 bits.
REQ-020 C <= ALU result when en_C=1; datapath_out = C at all times.
REQ-021 On en_status=1: Z <= (result==0), N <= result[15], V <= signed overflow for ADD/SUB, 0 for AND/MVN.
REQ-022 Status updates independently of en_C; en_status=0 holds Z/N/V.
REQ-023 All enables simultaneous in one cycle act independently on the same edge; ALU operands use pre-edge A/B values.
REQ-024 opcode/ALU_op/shift_op reflect the IR, changing the cycle after load_ir edge.
REQ-025 Latency Rm/Rn read -> Rd write: 1 edge load A/B, 1 edge load C, 1 edge write (3 edges minimum).

Reset
REQ-026 rst=1 immediately clears IR, A, B, C, R0-R7, Z, N, V to 0; all outputs 0.
REQ-027 While rst=1 all enables (load_ir, w_en, en_*) are ignored.
REQ-028 Reset mid-operation abandons any partial instruction; no write completes on the edge where rst is high.

Configuration
REQ-029 Macro CPU_DATAPATH_SHIFTER_EN defined: shifter per REQ-018.
REQ-030 Macro undefined: shifter is pass-through for all shift_op values; shift_op output still reflects IR[4:3].

Verification
REQ-031 MOVI: IR=16'hD105 (Rn=R1, imm8=5), reg_sel=10, wb_sel=10, w_en pulse -> R1=16'h0005.
REQ-032 ADD: R1=5, R2=7; load B from Rm=R2, A from Rn=R1, sel_A=0, sel_B=0, ALU_op=00, en_C, write Rd -> datapath_out=16'h000C, Rd=12.
REQ-033 CMP: A=16'h7FFF, B=16'hFFFF, ALU_op=01, en_status -> Z=0, N=1, V=1; C unchanged.
REQ-034 Shift: B=16'h8001, shift_op=11, sel_A=1, ALU_op=00, en_C -> C=16'hC000 (macro defined), 16'h8001 (undefined).
REQ-035 Reset mid-op: R3=16'h1234, w_en=1 with rst asserted between edges -> all registers 0, no write lands; after release R3 reads 0.
REQ-036 Same-register hazard: w_en to R4 and en_A from R4 on one edge -> A holds old R4, R4 holds new value.

Source files
------------

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//
// Purpose:
//   16-bit single-issue CPU datapath: instruction register with field decode,
//   8 x 16-bit register file, A/B operand registers, shifter on B, 4-function
//   ALU, C result register and Z/N/V status register. All sequencing comes
//   from an external controller through the enable/select inputs.
//
// Configuration:
//   CPU_DATAPATH_SHIFTER_EN  defined   -> shifter implements pass/LSL/LSR/ASR
//                            undefined -> shifter is pass-through for every
//                                         shift_op (shift_op still decoded)
//
// Ports:
//   clk           in   1   rising-edge clock for all state
//   rst           in   1   asynchronous active-high reset
//   instr_in      in  16   instruction word, captured when load_ir=1
//   load_ir       in   1   IR load enable
//   reg_sel       in   2   register pointer: 00=Rm 01=Rd 10=Rn 11=Rm
//   wb_sel        in   2   writeback source: 00=C 01={8'b0,pc} 10=sximm8 11=mdata
//   w_en          in   1   register file write enable
//   en_A, en_B    in   1   operand register load enables
//   en_C          in   1   result register load enable
//   en_status     in   1   status register load enable
//   sel_A         in   1   1: ALU A operand is zero, 0: A register
//   sel_B         in   1   1: ALU B operand is sximm5, 0: shifter output
//   mdata         in  16   memory read data
//   pc            in   8   program counter
//   opcode        out  3   IR[15:13]
//   ALU_op        out  2   IR[12:11]
//   shift_op      out  2   IR[4:3]
//   datapath_out  out 16   C register
//   Z, N, V       out  1   status register
// ---------------------------------------------------------------------------
module cpu_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        load_ir,
  input  logic [1:0]  reg_sel,
  input  logic [1:0]  wb_sel,
  input  logic        w_en,
  input  logic        en_A,
  input  logic        en_B,
  input  logic        en_C,
  input  logic        en_status,
  input  logic        sel_A,
  input  logic        sel_B,
  input  logic [15:0] mdata,
  input  logic [7:0]  pc,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [15:0] datapath_out,
  output logic        Z,
  output logic        N,
  output logic        V
);

  typedef enum logic [1:0] {
    PTR_RM  = 2'b00,
    PTR_RD  = 2'b01,
    PTR_RN  = 2'b10,
    PTR_RM2 = 2'b11
  } reg_sel_e;

  typedef enum logic [1:0] {
    WB_C     = 2'b00,
    WB_PC    = 2'b01,
    WB_IMM8  = 2'b10,
    WB_MDATA = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  // Architectural state
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q,  a_d;
  logic [15:0] b_q,  b_d;
  logic [15:0] c_q,  c_d;
  logic        z_q,  z_d;
  logic        n_q,  n_d;
  logic        v_q,  v_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  // Instruction field decode
  logic [2:0]  rn_idx, rd_idx, rm_idx;
  logic [15:0] sximm8, sximm5;

  assign rn_idx = ir_q[10:8];
  assign rd_idx = ir_q[7:5];
  assign rm_idx = ir_q[2:0];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  // Register pointer shared by read port and write port
  logic [2:0] sel_ptr;

  always_comb begin
    sel_ptr = rm_idx;
    case (reg_sel_e'(reg_sel))
      PTR_RD:  sel_ptr = rd_idx;
      PTR_RN:  sel_ptr = rn_idx;
      default: sel_ptr = rm_idx;
    endcase
  end

  // Read is taken from the pre-edge array, so a same-edge write is never
  // forwarded into A or B.
  logic [15:0] rdata;
  assign rdata = rf_q[sel_ptr];

  // Writeback source mux
  logic [15:0] wb_data;

  always_comb begin
    wb_data = c_q;
    case (wb_sel_e'(wb_sel))
      WB_C:     wb_data = c_q;
      WB_PC:    wb_data = {8'h00, pc};
      WB_IMM8:  wb_data = sximm8;
      WB_MDATA: wb_data = mdata;
      default:  wb_data = c_q;
    endcase
  end

  // Shifter on B
  logic [15:0] shift_out;

  always_comb begin
    shift_out = b_q;
`ifdef CPU_DATAPATH_SHIFTER_EN
    case (shift_op_e'(ir_q[4:3]))
      SH_PASS: shift_out = b_q;
      SH_LSL:  shift_out = {b_q[14:0], 1'b0};
      SH_LSR:  shift_out = {1'b0, b_q[15:1]};
      SH_ASR:  shift_out = {b_q[15], b_q[15:1]};
      default: shift_out = b_q;
    endcase
`else
    shift_out = b_q;
`endif
  end

  // ALU operand selection
  logic [15:0] alu_a, alu_b;

  assign alu_a = sel_A ? '0 : a_q;
  assign alu_b = sel_B ? sximm5 : shift_out;

  // ALU. Overflow: ADD overflows when operands share a sign that the result
  // does not; SUB when operand signs differ and the result sign leaves A's.
  logic [15:0] alu_res;
  logic        alu_v;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op_e'(ir_q[12:11]))
      ALU_ADD: begin
        alu_res = alu_a + alu_b;
        alu_v   = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
      end
      ALU_SUB: begin
        alu_res = alu_a - alu_b;
        alu_v   = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
      end
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_MVN: alu_res = ~alu_b;
      default: alu_res = '0;
    endcase
  end

  // Next-state: every enable acts independently on the same edge
  always_comb begin
    ir_d = ir_q;
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    z_d  = z_q;
    n_d  = n_q;
    v_d  = v_q;
    rf_d = rf_q;

    if (load_ir)   ir_d = instr_in;
    if (en_A)      a_d  = rdata;
    if (en_B)      b_d  = rdata;
    if (en_C)      c_d  = alu_res;
    if (en_status) begin
      z_d = (alu_res == '0);
      n_d = alu_res[15];
      v_d = alu_v;
    end
    if (w_en)      rf_d[sel_ptr] = wb_data;
  end

  // Reset has priority over every enable, so a write pending on a reset edge
  // is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      v_q  <= 1'b0;
      rf_q <= '{default: '0};
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      z_q  <= z_d;
      n_q  <= n_d;
      v_q  <= v_d;
      rf_q <= rf_d;
    end
  end

  assign opcode       = ir_q[15:13];
  assign ALU_op       = ir_q[12:11];
  assign shift_op     = ir_q[4:3];
  assign datapath_out = c_q;
  assign Z            = z_q;
  assign N            = n_q;
  assign V            = v_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath
//
// Self-checking bench for cpu_datapath. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output
// is sampled (1 time unit after the rising edge).
// Honours CPU_DATAPATH_SHIFTER_EN for the shifter reference.
// ---------------------------------------------------------------------------
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        load_ir;
  logic [1:0]  reg_sel;
  logic [1:0]  wb_sel;
  logic        w_en, en_A, en_B, en_C, en_status;
  logic        sel_A, sel_B;
  logic [15:0] mdata;
  logic [7:0]  pc;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op, shift_op;
  logic [15:0] datapath_out;
  logic        Z, N, V;

  cpu_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .load_ir      (load_ir),
    .reg_sel      (reg_sel),
    .wb_sel       (wb_sel),
    .w_en         (w_en),
    .en_A         (en_A),
    .en_B         (en_B),
    .en_C         (en_C),
    .en_status    (en_status),
    .sel_A        (sel_A),
    .sel_B        (sel_B),
    .mdata        (mdata),
    .pc           (pc),
    .opcode       (opcode),
    .ALU_op       (ALU_op),
    .shift_op     (shift_op),
    .datapath_out (datapath_out),
    .Z            (Z),
    .N            (N),
    .V            (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state
  logic [15:0] m_r [8];
  logic [15:0] m_c;
  logic [2:0]  m_f;   // {Z,N,V}

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [15:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [15:0] flags();
    return {13'b0, Z, N, V};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_ir = 0; w_en = 0; en_A = 0; en_B = 0; en_C = 0; en_status = 0;
    sel_A = 0; sel_B = 0;
  endtask

  // Reference models, written independently of the RTL structure
  function automatic logic [15:0] shift_ref(input logic [15:0] b, input logic [1:0] sh);
`ifdef CPU_DATAPATH_SHIFTER_EN
    logic signed [15:0] sb;
    sb = b;
    case (sh)
      2'd1:    return b << 1;
      2'd2:    return b >> 1;
      2'd3:    return sb >>> 1;
      default: return b;
    endcase
`else
    case (sh)
      default: return b;
    endcase
`endif
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] x);
    logic signed [15:0] s;
    s = $signed(x);
    return s;
  endfunction

  // Returns {result, Z, N, V}
  function automatic logic [18:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    int          sa, sb, full;
    logic [15:0] r;
    logic        v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    case (op)
      2'd0: begin full = sa + sb; r = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd1: begin full = sa - sb; r = 16'(full); v = (full > 32767) || (full < -32768); end
      2'd2: r = a & b;
      default: r = ~b;
    endcase
    return {r, (r == 16'h0000), r[15], v};
  endfunction

  task automatic load_instr(input logic [15:0] ir);
    instr_in = ir;
    load_ir  = 1;
    expect_val("opcode",   {13'b0, ir[15:13]});
    expect_val("alu_op",   {14'b0, ir[12:11]});
    expect_val("shift_op", {14'b0, ir[4:3]});
    step();
    load_ir = 0;
    observe({13'b0, opcode});
    observe({14'b0, ALU_op});
    observe({14'b0, shift_op});
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
    load_instr({3'b110, 2'b10, r, 8'h00});
    reg_sel = 2'b10; wb_sel = 2'b11; mdata = v; w_en = 1;
    step();
    w_en = 0;
    m_r[r] = v;
  endtask

  // Route R[r] through B, shifter pass and 0+B into C
  task automatic read_reg(input logic [2:0] r, input string tag);
    load_instr({3'b101, 2'b00, 3'b000, 3'b000, 2'b00, r});
    reg_sel = 2'b00; en_B = 1;
    step();
    en_B = 0; sel_A = 1; sel_B = 0; en_C = 1;
    m_c = m_r[r];
    expect_val(tag, m_c);
    step();
    en_C = 0; sel_A = 0;
    observe(datapath_out);
  endtask

  task automatic run_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic [1:0] sh, input logic sa, input logic sb);
    logic [15:0] opa, opb;
    logic [18:0] res;
    write_reg(3'd1, a);
    write_reg(3'd2, b);
    load_instr({3'b101, op, 3'b001, 3'b000, sh, 3'b010});
    reg_sel = 2'b10; en_A = 1;
    step();
    en_A = 0; reg_sel = 2'b00; en_B = 1;
    step();
    en_B = 0;
    opa = sa ? 16'h0000 : a;
    opb = sb ? sext5({sh, 3'b010}) : shift_ref(b, sh);
    res = alu_ref(opa, opb, op);
    m_c = res[18:3];
    m_f = res[2:0];
    sel_A = sa; sel_B = sb; en_C = 1; en_status = 1;
    expect_val("alu_c", m_c);
    expect_val("alu_flags", {13'b0, m_f});
    step();
    idle();
    observe(datapath_out);
    observe(flags());
  endtask

  logic [15:0] da [8] = '{16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'hAAAA, 16'h5555};
  logic [15:0] db [8] = '{16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'h0000, 16'hFFFF, 16'h5555, 16'hF0F0};
  logic [1:0]  dop[8] = '{2'd0,     2'd1,     2'd1,     2'd0,     2'd2,     2'd0,     2'd3,     2'd2};

  initial begin
    rst = 1; instr_in = '0; reg_sel = '0; wb_sel = '0; mdata = '0; pc = '0;
    idle();
    m_r = '{default: '0};
    m_c = '0;
    m_f = '0;

    // Reset state
    step();
    step();
    rst = 0;
    expect_val("rst_out", 16'h0000);
    expect_val("rst_flags", 16'h0000);
    expect_val("rst_opcode", 16'h0000);
    observe(datapath_out);
    observe(flags());
    observe({13'b0, opcode});

    // MOVI R1, #5
    load_instr(16'hD105);
    reg_sel = 2'b10; wb_sel = 2'b10; w_en = 1;
    step();
    w_en = 0;
    m_r[1] = 16'h0005;
    read_reg(3'd1, "movi_r1");

    // ADD R3 = R1 + R2
    write_reg(3'd2, 16'h0007);
    load_instr({3'b101, 2'b00, 3'b001, 3'b011, 2'b00, 3'b010});
    reg_sel = 2'b00; en_B = 1;
    step();
    en_B = 0; reg_sel = 2'b10; en_A = 1;
    step();
    en_A = 0; sel_A = 0; sel_B = 0; en_C = 1;
    m_c = 16'h000C;
    expect_val("add_c", m_c);
    expect_val("add_flags_held", {13'b0, m_f});
    step();
    en_C = 0;
    observe(datapath_out);
    observe(flags());
    reg_sel = 2'b01; wb_sel = 2'b00; w_en = 1;
    step();
    w_en = 0;
    m_r[3] = 16'h000C;
    read_reg(3'd3, "add_rd");

    // CMP: status only, C untouched
    write_reg(3'd4, 16'h7FFF);
    write_reg(3'd5, 16'hFFFF);
    load_instr({3'b101, 2'b01, 3'b100, 3'b000, 2'b00, 3'b101});
    reg_sel = 2'b10; en_A = 1;
    step();
    en_A = 0; reg_sel = 2'b00; en_B = 1;
    step();
    en_B = 0; en_status = 1;
    m_f = 3'b011;
    expect_val("cmp_c_held", m_c);
    expect_val("cmp_flags", 16'h0003);
    step();
    en_status = 0;
    observe(datapath_out);
    observe(flags());

    // ASR of 0x8001 via 0+B
    write_reg(3'd6, 16'h8001);
    load_instr({3'b101, 2'b00, 3'b000, 3'b000, 2'b11, 3'b110});
    reg_sel = 2'b00; en_B = 1;
    step();
    en_B = 0; sel_A = 1; sel_B = 0; en_C = 1;
`ifdef CPU_DATAPATH_SHIFTER_EN
    m_c = 16'hC000;
`else
    m_c = 16'h8001;
`endif
    expect_val("asr_c", m_c);
    expect_val("asr_flags_held", {13'b0, m_f});
    step();
    idle();
    observe(datapath_out);
    observe(flags());

    // Directed ALU corners, then random operations
    for (int i = 0; i < 8; i++) run_alu(da[i], db[i], dop[i], 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_alu(16'h8421, 16'hC003, 2'd0, 2'(i), 1'b1, 1'b0);
    for (int i = 0; i < 24; i++)
      run_alu(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Same-edge write and read of R4: A takes the old value
    write_reg(3'd4, 16'h1111);
    load_instr({3'b101, 2'b00, 3'b100, 3'b000, 2'b00, 3'b000});
    reg_sel = 2'b10; wb_sel = 2'b11; mdata = 16'h2222; w_en = 1; en_A = 1;
    step();
    w_en = 0; en_A = 0;
    m_r[4] = 16'h2222;
    sel_A = 0; sel_B = 1; en_C = 1;
    m_c = 16'h1111;
    expect_val("hazard_a_old", m_c);
    step();
    idle();
    observe(datapath_out);
    read_reg(3'd4, "hazard_r4_new");

    // PC writeback
    load_instr({3'b110, 2'b10, 3'b111, 8'h00});
    reg_sel = 2'b10; wb_sel = 2'b01; pc = 8'hA5; w_en = 1;
    step();
    w_en = 0;
    m_r[7] = 16'h00A5;
    read_reg(3'd7, "pc_wb_r7");

    // Reset mid-operation with every enable asserted
    write_reg(3'd3, 16'h1234);
    read_reg(3'd3, "r3_pre_rst");
    load_instr({3'b110, 2'b10, 3'b011, 8'h00});
    reg_sel = 2'b10; wb_sel = 2'b11; mdata = 16'h5555;
    w_en = 1; en_A = 1; en_B = 1; en_C = 1; en_status = 1;
    instr_in = 16'hFFFF; load_ir = 1;
    #2;
    rst = 1;
    #1;
    expect_val("rst_async_out", 16'h0000);
    expect_val("rst_async_flags", 16'h0000);
    expect_val("rst_async_opcode", 16'h0000);
    observe(datapath_out);
    observe(flags());
    observe({13'b0, opcode});
    step();
    expect_val("rst_edge_out", 16'h0000);
    expect_val("rst_edge_opcode", 16'h0000);
    observe(datapath_out);
    observe({13'b0, opcode});
    idle();
    #1;
    rst = 0;
    m_r = '{default: '0};
    m_c = '0;
    m_f = '0;
    read_reg(3'd3, "r3_post_rst");
    read_reg(3'd1, "r1_post_rst");
    expect_val("flags_post_rst", 16'h0000);
    observe(flags());

    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
